a2d_spi_resp: RTL and testbench

- 16-bit SPI responder (slave) that answers the A2D interface's SPI master; a synthesizable, bench-reusable stand-in for the external 8-channel 12-bit A2D converter.
- Decodes the channel field of each command frame.
- Returns that channel's 12-bit conversion during the following frame (one-frame pipeline).
- Channel values come from a parallel input bus driven by the testbench or plant model.

---
 rtl/a2d_pkg.sv | 15 +
 rtl/a2d_spi_resp_if.sv | 14 +
 rtl/a2d_sync_edge.sv | 31 +++
 rtl/a2d_spi_resp.sv | 126 ++++++++++++
 tb/tb_a2d_spi_resp.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/a2d_pkg.sv
// a2d_pkg: shared types and constants for the A2D SPI responder.
//   frm_state_e        : frame FSM state (IDLE / ACTIVE)
//   CHNL_MSB/CHNL_LSB  : channel field position inside the 16-bit command
//   FRM_BITS           : SCLK rises in a complete frame
//   LFSR_SEED/LFSR_TAPS: noise LFSR seed and Fibonacci tap mask (taps 8,6,5,4)
package a2d_pkg;
  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} frm_state_e;

  localparam int CHNL_MSB = 13;
  localparam int CHNL_LSB = 11;
  localparam int FRM_BITS = 16;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;  // bits 7,5,4,3 = taps 8,6,5,4
endpackage

// File: rtl/a2d_spi_resp_if.sv
// a2d_spi_resp_if: 4-wire SPI bundle between the A2D master and responder.
//   SS_n : slave select, active low (master -> slave)
//   SCLK : serial clock, idles high (master -> slave)
//   MOSI : command data, MSB first (master -> slave)
//   MISO : response data, MSB first (slave -> master)
interface a2d_spi_resp_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (output SS_n, SCLK, MOSI, input MISO);
  modport slave  (input SS_n, SCLK, MOSI, output MISO);
endinterface

// File: rtl/a2d_sync_edge.sv
// a2d_sync_edge: 2-flop synchronizer plus one edge flop.
//   clk, rst_n : system clock, async active-low reset
//   d          : asynchronous input
//   rise, fall : one-clk pulses on a synchronized 0->1 / 1->0 transition
// All three flops reset to RST_VAL so nothing is detected out of reset.
module a2d_sync_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
      s3 <= RST_VAL;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
endmodule

// File: rtl/a2d_spi_resp.sv
// a2d_spi_resp: 16-bit SPI responder emulating an 8-channel 12-bit A2D.
//   clk, rst_n : system clock (>= 8x SCLK), async active-low reset
//   spi        : slave modport (SS_n, SCLK, MOSI in; MISO out)
//   chnl_data  : channel k at bits [k*DATA_W +: DATA_W]
//   cmd_vld    : one-clk pulse at the end of a complete frame
//   cmd_chnl   : channel decoded from the last complete frame
//   frm_err    : one-clk pulse when a frame ends short
// Each frame returns the channel commanded by the previous complete frame.
// Optional macro A2D_NOISE_EN: XOR an 8-bit LFSR into the two response LSBs.
module a2d_spi_resp
  import a2d_pkg::*;
#(
  parameter int DATA_W   = 12,
  parameter int NUM_CH   = 8,
  parameter int FRM_BITS = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  a2d_spi_resp_if.slave                    spi,
  input  logic [NUM_CH-1:0][DATA_W-1:0]    chnl_data,
  output logic                             cmd_vld,
  output logic [$clog2(NUM_CH)-1:0]        cmd_chnl,
  output logic                             frm_err
);
  localparam int CNT_W = $clog2(FRM_BITS + 1);
  localparam int CH_W  = $clog2(NUM_CH);

  frm_state_e            state, state_nxt;
  logic [FRM_BITS-1:0]   shreg, shreg_nxt, load_word;
  logic [CNT_W-1:0]      bit_cnt, cnt_nxt;
  logic [CH_W-1:0]       chnl_nxt;
  logic                  vld_nxt, err_nxt;
  logic                  ss_rise, ss_fall, sclk_rise, sclk_fall;
  logic                  mosi_s1, mosi_s2;

  a2d_sync_edge #(.RST_VAL(1'b1)) u_ss (
    .clk (clk), .rst_n(rst_n), .d(spi.SS_n), .rise(ss_rise), .fall(ss_fall)
  );
  a2d_sync_edge #(.RST_VAL(1'b1)) u_sclk (
    .clk (clk), .rst_n(rst_n), .d(spi.SCLK), .rise(sclk_rise), .fall(sclk_fall)
  );

  // Same depth as the SCLK synchronizer so the sampled bit lines up with
  // the detected rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      mosi_s1 <= spi.MOSI;
      mosi_s2 <= mosi_s1;
    end
  end

`ifdef A2D_NOISE_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       lfsr <= LFSR_SEED;
    else if (vld_nxt) lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
  end

  assign load_word = {{(FRM_BITS-DATA_W){1'b0}}, chnl_data[cmd_chnl]}
                   ^ {{(FRM_BITS-2){1'b0}}, lfsr[1:0]};
`else
  assign load_word = {{(FRM_BITS-DATA_W){1'b0}}, chnl_data[cmd_chnl]};
`endif

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = bit_cnt;
    chnl_nxt  = cmd_chnl;
    vld_nxt   = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          shreg_nxt = load_word;
          cnt_nxt   = '0;
          state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        // SS_n rise takes priority; a coincident SCLK rise is dropped.
        if (ss_rise) begin
          state_nxt = IDLE;
          if (bit_cnt == CNT_W'(FRM_BITS)) begin
            vld_nxt  = 1'b1;
            chnl_nxt = shreg[CHNL_MSB:CHNL_LSB];
          end else begin
            err_nxt  = 1'b1;
          end
        end else if (sclk_rise && bit_cnt < CNT_W'(FRM_BITS)) begin
          shreg_nxt = {shreg[FRM_BITS-2:0], mosi_s2};
          cnt_nxt   = bit_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      cmd_chnl <= '0;
      cmd_vld  <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      bit_cnt  <= cnt_nxt;
      cmd_chnl <= chnl_nxt;
      cmd_vld  <= vld_nxt;
      frm_err  <= err_nxt;
    end
  end

  // SCLK falling edges carry no meaning for this responder.
  logic unused_ok;
  assign unused_ok = sclk_fall;

  assign spi.MISO = (state == ACTIVE) & shreg[FRM_BITS-1];
endmodule

// File: tb/tb_a2d_spi_resp.sv
// tb_a2d_spi_resp: directed bench for a2d_spi_resp. Acts as SPI master with
// SCLK half-period of 8 clk, collects MISO at each SCLK rise and checks
// response words, cmd_vld/frm_err pulses and latency, cmd_chnl, reset.
module tb_a2d_spi_resp;
  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [7:0][11:0]     chnl_data;
  logic                 cmd_vld, frm_err;
  logic [2:0]           cmd_chnl;
  int                   n_cmp = 0;
  int                   n_mis = 0;

  a2d_spi_resp_if spi ();

  a2d_spi_resp dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .spi      (spi),
    .chnl_data(chnl_data),
    .cmd_vld  (cmd_vld),
    .cmd_chnl (cmd_chnl),
    .frm_err  (frm_err)
  );

  always #5 clk = ~clk;

`ifdef A2D_NOISE_EN
  logic [7:0] lfsr_m = 8'hA5;
`endif

  // Expected response word for a channel value.
  function automatic logic [15:0] resp(input logic [11:0] d);
    logic [15:0] r;
    r = {4'h0, d};
`ifdef A2D_NOISE_EN
    r[1:0] = r[1:0] ^ lfsr_m[1:0];
`endif
    return r;
  endfunction

  task automatic adv();
`ifdef A2D_NOISE_EN
    lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
`endif
  endtask

  task automatic model_reset();
`ifdef A2D_NOISE_EN
    lfsr_m = 8'hA5;
`endif
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One master frame. nbits SCLK rises (bits past 16 send 1s). rst_at > 0
  // asserts rst_n just after that rise and abandons the frame.
  task automatic frame(input logic [15:0] cmd, input int nbits, input int rst_at,
                       output logic [15:0] rx, output int nvld, output int nerr,
                       output int lat);
    bit aborted = 1'b0;
    rx = '0; nvld = 0; nerr = 0; lat = 0;
    @(negedge clk);
    spi.SS_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits && !aborted; i++) begin
      spi.SCLK = 1'b0;
      spi.MOSI = (i < 16) ? cmd[15-i] : 1'b1;
      repeat (8) @(negedge clk);
      if (i < 16) rx = {rx[14:0], spi.MISO};
      spi.SCLK = 1'b1;
      if (i + 1 == rst_at) begin
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        check("rst_mid_miso", 32'(spi.MISO), 32'd0);
        check("rst_mid_chnl", 32'(cmd_chnl), 32'd0);
        check("rst_mid_vld",  32'(cmd_vld | frm_err), 32'd0);
        spi.SS_n = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        aborted = 1'b1;
      end else begin
        repeat (8) @(negedge clk);
      end
    end
    spi.SS_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (cmd_vld) nvld++;
      if (frm_err) nerr++;
      if ((cmd_vld | frm_err) && lat == 0) lat = k;
    end
  endtask

  initial begin
    logic [15:0] rx;
    int nv, ne, lt;

    rst_n    = 1'b0;
    spi.SS_n = 1'b1;
    spi.SCLK = 1'b1;
    spi.MOSI = 1'b0;
    chnl_data[0] = 12'h123; chnl_data[1] = 12'h456;
    chnl_data[2] = 12'h789; chnl_data[3] = 12'h5A5;
    chnl_data[4] = 12'hABC; chnl_data[5] = 12'hFFF;
    chnl_data[6] = 12'h0F0; chnl_data[7] = 12'h321;
    repeat (3) @(negedge clk);
    check("rst_miso", 32'(spi.MISO), 32'd0);
    check("rst_vld",  32'(cmd_vld),  32'd0);
    check("rst_err",  32'(frm_err),  32'd0);
    check("rst_chnl", 32'(cmd_chnl), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // first frame after reset returns ch0, commands ch4
    frame(16'h2000, 16, 0, rx, nv, ne, lt);
    check("f1_rx", 32'(rx), 32'(resp(12'h123)));
    check("f1_vld", 32'(nv), 32'd1);
    check("f1_err", 32'(ne), 32'd0);
    check("f1_lat", 32'(lt), 32'd3);
    check("f1_chnl", 32'(cmd_chnl), 32'd4);
    adv();

    frame(16'h2800, 16, 0, rx, nv, ne, lt);
    check("f2_rx", 32'(rx), 32'(resp(12'hABC)));
    check("f2_chnl", 32'(cmd_chnl), 32'd5);
    adv();

    frame(16'h0000, 16, 0, rx, nv, ne, lt);
    check("f3_rx", 32'(rx), 32'(resp(12'hFFF)));
    check("f3_chnl", 32'(cmd_chnl), 32'd0);
    adv();

    // short frame: 9 rises, top 9 bits of 0x0123 = 0x002
    frame(16'h3800, 9, 0, rx, nv, ne, lt);
    check("short_rx", 32'(rx), 32'h0002);
    check("short_err", 32'(ne), 32'd1);
    check("short_vld", 32'(nv), 32'd0);
    check("short_lat", 32'(lt), 32'd3);
    check("short_chnl", 32'(cmd_chnl), 32'd0);

    frame(16'h1800, 16, 0, rx, nv, ne, lt);
    check("after_short_rx", 32'(rx), 32'(resp(12'h123)));
    check("after_short_chnl", 32'(cmd_chnl), 32'd3);
    adv();

    // 18 rises: only first 16 count, channel 6 decoded from them
    frame(16'h3000, 18, 0, rx, nv, ne, lt);
    check("long_rx", 32'(rx), 32'(resp(12'h5A5)));
    check("long_vld", 32'(nv), 32'd1);
    check("long_err", 32'(ne), 32'd0);
    check("long_chnl", 32'(cmd_chnl), 32'd6);
    adv();

    frame(16'h0800, 16, 0, rx, nv, ne, lt);
    check("f7_rx", 32'(rx), 32'(resp(12'h0F0)));
    check("f7_chnl", 32'(cmd_chnl), 32'd1);
    adv();

    // reset at bit 7 of a ch2 command
    frame(16'h1000, 16, 7, rx, nv, ne, lt);
    check("rst_frame_vld", 32'(nv), 32'd0);
    check("rst_frame_err", 32'(ne), 32'd0);
    check("rst_frame_chnl", 32'(cmd_chnl), 32'd0);

    frame(16'h2000, 16, 0, rx, nv, ne, lt);
    check("post_rst_rx", 32'(rx), 32'(resp(12'h123)));
    check("post_rst_chnl", 32'(cmd_chnl), 32'd4);
    check("post_rst_vld", 32'(nv), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
